// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite responder backed by a word-organised RAM with byte enables.
// Read and write channels run independent FSMs with configurable response latency.
module axi_lite_mem_responder #(
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int          DEPTH  = 4096,
    parameter int          RD_LAT = 1,
    parameter int          WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;
    localparam int          RCW   = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam int          WCW   = (WR_LAT < 1) ? 1 : $clog2(WR_LAT + 1);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;

    logic [31:0]      r_mem [DEPTH];

    rstate_t          r_rstate;
    logic [31:0]      r_araddr;
    logic [RCW-1:0]   r_rcnt;
    logic             r_arready;
    logic             r_rvalid;
    logic [31:0]      r_rdata;
    logic [1:0]       r_rresp;

    wstate_t          r_wstate;
    logic [31:0]      r_awaddr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic [WCW-1:0]   r_wcnt;
    logic             r_awready;
    logic             r_wready;
    logic             r_bvalid;
    logic [1:0]       r_bresp;

    logic [31:0]      w_rdOff;
    logic [31:0]      w_wrOff;
    logic             w_rdInRange;
    logic             w_wrInRange;
    logic [IDX_W-1:0] w_rdIdx;
    logic [IDX_W-1:0] w_wrIdx;
    logic             w_awAcc;
    logic             w_wAcc;
    logic             w_commit;

    // Offsets below BASE wrap to large values, so the explicit >= BASE test keeps them out.
    assign w_rdOff     = r_araddr - BASE;
    assign w_wrOff     = r_awaddr - BASE;
    assign w_rdInRange = (r_araddr >= BASE) && ({1'b0, w_rdOff} < SPAN);
    assign w_wrInRange = (r_awaddr >= BASE) && ({1'b0, w_wrOff} < SPAN);
    assign w_rdIdx     = w_rdOff[IDX_W+1:2];
    assign w_wrIdx     = w_wrOff[IDX_W+1:2];

    assign w_awAcc  = awvalid && r_awready;
    assign w_wAcc   = wvalid && r_wready;
    assign w_commit = (r_wstate == W_WAIT) && (r_wcnt == '0) && w_wrInRange;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate  <= R_IDLE;
            r_araddr  <= '0;
            r_rcnt    <= '0;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (arvalid && r_arready) begin
                        r_araddr  <= araddr;
                        r_rcnt    <= RCW'(RD_LAT);
                        r_arready <= 1'b0;
                        r_rstate  <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (r_rcnt == '0) begin
                        r_rdata  <= w_rdInRange ? r_mem[w_rdIdx] : 32'h0;
                        r_rresp  <= w_rdInRange ? 2'b00 : 2'b11;
                        r_rvalid <= 1'b1;
                        r_rstate <= R_RESP;
                    end else begin
                        r_rcnt <= r_rcnt - RCW'(1);
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // AW and W are captured independently; the second arrival (or a joint one) starts the wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wcnt    <= '0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_awAcc) begin
                        r_awaddr  <= awaddr;
                        r_awready <= 1'b0;
                    end
                    if (w_wAcc) begin
                        r_wdata  <= wdata;
                        r_wstrb  <= wstrb;
                        r_wready <= 1'b0;
                    end
                    if ((w_awAcc || !r_awready) && (w_wAcc || !r_wready)) begin
                        r_wcnt   <= WCW'(WR_LAT);
                        r_wstate <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (r_wcnt == '0) begin
                        r_bresp  <= w_wrInRange ? 2'b00 : 2'b11;
                        r_bvalid <= 1'b1;
                        r_wstate <= W_RESP;
                    end else begin
                        r_wcnt <= r_wcnt - WCW'(1);
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // RAM contents survive reset; a same-edge read sees the pre-commit word.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wstrb[b]) begin
                    r_mem[w_wrIdx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed self-checking bench for axi_lite_mem_responder.
// Two instances: latency 1/1 (sel=0) and latency 0/0 (sel=1), sharing payload inputs.
module tb_axi_lite_mem_responder;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [31:0] araddr, awaddr, wdata;
    logic [3:0]  wstrb;
    logic        arvalid, rready, awvalid, wvalid, bready;

    logic        arreadyA, rvalidA, awreadyA, wreadyA, bvalidA;
    logic [31:0] rdataA;
    logic [1:0]  rrespA, brespA;
    logic        arreadyZ, rvalidZ, awreadyZ, wreadyZ, bvalidZ;
    logic [31:0] rdataZ;
    logic [1:0]  rrespZ, brespZ;

    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;

    int nCompared;
    int nMismatched;

    assign arready = sel ? arreadyZ : arreadyA;
    assign rvalid  = sel ? rvalidZ  : rvalidA;
    assign rdata   = sel ? rdataZ   : rdataA;
    assign rresp   = sel ? rrespZ   : rrespA;
    assign awready = sel ? awreadyZ : awreadyA;
    assign wready  = sel ? wreadyZ  : wreadyA;
    assign bvalid  = sel ? bvalidZ  : bvalidA;
    assign bresp   = sel ? brespZ   : brespA;

    axi_lite_mem_responder #(.BASE(32'h8000_0000), .DEPTH(4096), .RD_LAT(1), .WR_LAT(1)) dutA (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid & ~sel), .arready(arreadyA),
        .rdata(rdataA), .rresp(rrespA), .rvalid(rvalidA), .rready(rready & ~sel),
        .awaddr(awaddr), .awvalid(awvalid & ~sel), .awready(awreadyA),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid & ~sel), .wready(wreadyA),
        .bresp(brespA), .bvalid(bvalidA), .bready(bready & ~sel)
    );

    axi_lite_mem_responder #(.BASE(32'h8000_0000), .DEPTH(4096), .RD_LAT(0), .WR_LAT(0)) dutZ (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid & sel), .arready(arreadyZ),
        .rdata(rdataZ), .rresp(rrespZ), .rvalid(rvalidZ), .rready(rready & sel),
        .awaddr(awaddr), .awvalid(awvalid & sel), .awready(awreadyZ),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid & sel), .wready(wreadyZ),
        .bresp(brespZ), .bvalid(bvalidZ), .bready(bready & sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic ok);
        logic awDone, wDone, hsAw, hsW;
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        awDone = 1'b0; wDone = 1'b0; ok = 1'b0; resp = 2'bxx; n = 0;
        while (!(awDone && wDone) && n < 20) begin
            hsAw = awvalid && awready;
            hsW  = wvalid && wready;
            @(posedge clk); #1;
            if (hsAw) begin awvalid = 1'b0; awDone = 1'b1; end
            if (hsW)  begin wvalid = 1'b0;  wDone = 1'b1;  end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1; n = 0;
        while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (bvalid) begin
            resp = bresp;
            ok = awDone && wDone;
            @(posedge clk); #1;
        end
        bready = 1'b0;
    endtask

    task automatic doRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output logic ok);
        logic hs;
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        ok = 1'b0; data = 'x; resp = 'x; hs = 1'b0; n = 0;
        while (!hs && n < 20) begin
            hs = arvalid && arready;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0; rready = 1'b1; n = 0;
        while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
        if (rvalid && hs) begin
            data = rdata; resp = rresp; ok = 1'b1;
            @(posedge clk); #1;
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        nCompared++; if (arready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_arready: got %b want 1", arready); end
        nCompared++; if (awready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_awready: got %b want 1", awready); end
        nCompared++; if (wready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_wready: got %b want 1", wready); end
        nCompared++; if (rvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rvalid: got %b want 0", rvalid); end
        nCompared++; if (bvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_bvalid: got %b want 0", bvalid); end
        nCompared++; if (rdata !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
        nCompared++; if (rresp !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_rresp: got %b want 00", rresp); end
        nCompared++; if (bresp !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_bresp: got %b want 00", bresp); end
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        awaddr = 32'h8000_0000; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        nCompared++; if (awready !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_awready_drop: got %b want 0", awready); end
        nCompared++; if (wready !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_wready_drop: got %b want 0", wready); end
        @(posedge clk); #1;
        nCompared++; if (bvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_bvalid_early: got %b want 0", bvalid); end
        @(posedge clk); #1;
        nCompared++; if (bvalid !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_bvalid_lat: got %b want 1", bvalid); end
        nCompared++; if (bresp !== 2'b00) begin nMismatched++; $display("[TB] FAIL basic_bresp: got %b want 00", bresp); end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        nCompared++; if (bvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_bvalid_clear: got %b want 0", bvalid); end
        araddr = 32'h8000_0000; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        nCompared++; if (arready !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_arready_drop: got %b want 0", arready); end
        @(posedge clk); #1;
        nCompared++; if (rvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL basic_rvalid_early: got %b want 0", rvalid); end
        @(posedge clk); #1;
        nCompared++; if (rvalid !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_rvalid_lat: got %b want 1", rvalid); end
        nCompared++; if (rdata !== 32'hDEAD_BEEF) begin nMismatched++; $display("[TB] FAIL basic_rdata: got %h want deadbeef", rdata); end
        nCompared++; if (rresp !== 2'b00) begin nMismatched++; $display("[TB] FAIL basic_rresp: got %b want 00", rresp); end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        nCompared++; if (arready !== 1'b1) begin nMismatched++; $display("[TB] FAIL basic_arready_back: got %b want 1", arready); end
    endtask

    task automatic test_partial();
        logic [31:0] d;
        logic [1:0]  rs;
        logic        ok;
        doWrite(32'h8000_0004, 32'h1122_3344, 4'b1111, rs, ok);
        nCompared++; if (rs !== 2'b00) begin nMismatched++; $display("[TB] FAIL part_w1_resp: got %b want 00 (ok=%b)", rs, ok); end
        doWrite(32'h8000_0004, 32'h0000_00AA, 4'b0001, rs, ok);
        nCompared++; if (rs !== 2'b00) begin nMismatched++; $display("[TB] FAIL part_w2_resp: got %b want 00 (ok=%b)", rs, ok); end
        doWrite(32'h8000_0004, 32'h0000_BB00, 4'b0010, rs, ok);
        nCompared++; if (rs !== 2'b00) begin nMismatched++; $display("[TB] FAIL part_w3_resp: got %b want 00 (ok=%b)", rs, ok); end
        doRead(32'h8000_0006, d, rs, ok);
        nCompared++; if (ok !== 1'b1) begin nMismatched++; $display("[TB] FAIL part_rd_done: got %b want 1", ok); end
        nCompared++; if (d !== 32'h1122_BBAA) begin nMismatched++; $display("[TB] FAIL part_rdata: got %h want 1122bbaa", d); end
        doWrite(32'h8000_0004, 32'hFFFF_FFFF, 4'b0000, rs, ok);
        nCompared++; if (rs !== 2'b00) begin nMismatched++; $display("[TB] FAIL part_strb0_resp: got %b want 00 (ok=%b)", rs, ok); end
        doRead(32'h8000_0004, d, rs, ok);
        nCompared++; if (d !== 32'h1122_BBAA) begin nMismatched++; $display("[TB] FAIL part_strb0_rdata: got %h want 1122bbaa", d); end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0]  rs;
        logic        ok;
        awaddr = 32'h8000_0010; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        awvalid = 1'b0; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        wvalid = 1'b0;
        nCompared++; if (wready !== 1'b0) begin nMismatched++; $display("[TB] FAIL wfirst_wready_drop: got %b want 0", wready); end
        nCompared++; if (awready !== 1'b1) begin nMismatched++; $display("[TB] FAIL wfirst_awready_hold: got %b want 1", awready); end
        repeat (2) @(posedge clk);
        #1;
        nCompared++; if ((wready !== 1'b0) || (awready !== 1'b1)) begin nMismatched++; $display("[TB] FAIL wfirst_ready_wait: got w=%b aw=%b want w=0 aw=1", wready, awready); end
        awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        nCompared++; if (awready !== 1'b0) begin nMismatched++; $display("[TB] FAIL wfirst_awready_drop: got %b want 0", awready); end
        @(posedge clk); #1;
        nCompared++; if (bvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL wfirst_bvalid_early: got %b want 0", bvalid); end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            nCompared++; if ((bvalid !== 1'b1) || (bresp !== 2'b00)) begin nMismatched++; $display("[TB] FAIL wfirst_b_hold%0d: got bvalid=%b bresp=%b want 1/00", i, bvalid, bresp); end
            if (i < 4) begin @(posedge clk); #1; end
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        nCompared++; if (bvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL wfirst_bvalid_clear: got %b want 0", bvalid); end
        nCompared++; if ((awready !== 1'b1) || (wready !== 1'b1)) begin nMismatched++; $display("[TB] FAIL wfirst_ready_back: got aw=%b w=%b want 1/1", awready, wready); end
        doRead(32'h8000_0010, d, rs, ok);
        nCompared++; if (d !== 32'hCAFE_F00D) begin nMismatched++; $display("[TB] FAIL wfirst_rdata: got %h want cafef00d", d); end
    endtask

    task automatic test_decerr();
        logic [31:0] d;
        logic [1:0]  rs;
        logic        ok;
        doRead(32'h8000_4000, d, rs, ok);
        nCompared++; if (rs !== 2'b11) begin nMismatched++; $display("[TB] FAIL dec_rd_resp: got %b want 11 (ok=%b)", rs, ok); end
        nCompared++; if (d !== 32'h0) begin nMismatched++; $display("[TB] FAIL dec_rd_data: got %h want 0", d); end
        doRead(32'h8000_3FFC, d, rs, ok);
        nCompared++; if (rs !== 2'b00) begin nMismatched++; $display("[TB] FAIL dec_last_word_resp: got %b want 00 (ok=%b)", rs, ok); end
        doWrite(32'h7FFF_FFFC, 32'h1234_5678, 4'hF, rs, ok);
        nCompared++; if (rs !== 2'b11) begin nMismatched++; $display("[TB] FAIL dec_wr_resp: got %b want 11 (ok=%b)", rs, ok); end
        doRead(32'h8000_0000, d, rs, ok);
        nCompared++; if (d !== 32'hDEAD_BEEF) begin nMismatched++; $display("[TB] FAIL dec_word0_intact: got %h want deadbeef", d); end
    endtask

    task automatic test_same_edge();
        logic [31:0] d;
        logic [1:0]  rs;
        logic        ok;
        sel = 1'b1;
        #1;
        doWrite(32'h8000_0008, 32'h0000_0005, 4'hF, rs, ok);
        nCompared++; if (rs !== 2'b00) begin nMismatched++; $display("[TB] FAIL same_init_resp: got %b want 00 (ok=%b)", rs, ok); end
        araddr = 32'h8000_0008; awaddr = 32'h8000_0008; wdata = 32'h0000_0009; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b0; bready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        nCompared++; if ((rvalid !== 1'b0) || (bvalid !== 1'b0)) begin nMismatched++; $display("[TB] FAIL same_early: got r=%b b=%b want 0/0", rvalid, bvalid); end
        @(posedge clk); #1;
        nCompared++; if ((rvalid !== 1'b1) || (bvalid !== 1'b1)) begin nMismatched++; $display("[TB] FAIL same_lat0: got r=%b b=%b want 1/1", rvalid, bvalid); end
        nCompared++; if (rdata !== 32'h0000_0005) begin nMismatched++; $display("[TB] FAIL same_old_data: got %h want 00000005", rdata); end
        rready = 1'b1; bready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0; bready = 1'b0;
        doRead(32'h8000_0008, d, rs, ok);
        nCompared++; if (d !== 32'h0000_0009) begin nMismatched++; $display("[TB] FAIL same_new_data: got %h want 00000009", d); end
        sel = 1'b0;
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  rs;
        logic        ok;
        int          n;
        doWrite(32'h8000_0020, 32'hA5A5_A5A5, 4'hF, rs, ok);
        araddr = 32'h8000_0020; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 10) begin @(posedge clk); #1; n++; end
        nCompared++; if (rvalid !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstmid_in_resp: got %b want 1", rvalid); end
        #2 rst = 1'b1;
        #1;
        nCompared++; if (rvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_rvalid: got %b want 0", rvalid); end
        nCompared++; if (arready !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstmid_arready: got %b want 1", arready); end
        @(posedge clk); #1;
        rst = 1'b0;
        doRead(32'h8000_0020, d, rs, ok);
        nCompared++; if (d !== 32'hA5A5_A5A5) begin nMismatched++; $display("[TB] FAIL rstmid_ram_kept: got %h want a5a5a5a5", d); end
        doRead(32'h8000_0000, d, rs, ok);
        nCompared++; if (d !== 32'hDEAD_BEEF) begin nMismatched++; $display("[TB] FAIL rstmid_word0_kept: got %h want deadbeef", d); end
    endtask

    initial begin
        nCompared = 0; nMismatched = 0;
        sel = 1'b0; rst = 1'b1;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
        arvalid = 1'b0; rready = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        test_reset();
        test_basic();
        test_partial();
        test_w_before_aw();
        test_decerr();
        test_same_edge();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
